// File: rtl/cplx_pkg.sv
// ============================================================================
// Module      : cplx_pkg
// Description : Shared widths and FSM state encoding for the sequential
//               complex multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cplx_pkg;

  // Default operand width (signed two's complement)
  localparam int W_DEF = 8;

  // Accumulator / result width for the default operand width
  localparam int PW = 2 * W_DEF + 1;

  // Sequencer states: one partial product per M* state
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cplx_mult_seq_vedic.sv
// ============================================================================
// Module      : vedic_mult_u (with cells vedic_ha, vedic_cla)
// Description : Purely combinational unsigned NxN -> 2N multiplier built
//               recursively in the vedic (urdhva) style: four half-width
//               products recombined with carry-lookahead adders, bottoming
//               out in a 2x2 half-adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Half-adder cell
module vedic_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// N-bit adder using generate/propagate carry formulation (no carry out;
// callers size the operands so the sum cannot overflow)
module vedic_cla #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;

  // Carry computation from per-bit generate/propagate terms
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    for (int i = 0; i < N - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c;
  end
endmodule

// Recursive unsigned vedic multiplier
module vedic_mult_u #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_base
    logic c1;
    logic s1;
    assign p[0] = a[0] & b[0];
    vedic_ha u_ha0 (.a(a[1] & b[0]), .b(a[0] & b[1]), .s(s1), .c(c1));
    vedic_ha u_ha1 (.a(a[1] & b[1]), .b(c1), .s(p[2]), .c(p[3]));
    assign p[1] = s1;
  end else if ((N % 2 == 0) && (N >= 4)) begin : g_split
    localparam int H = N / 2;
    logic [N-1:0]   q0;
    logic [N-1:0]   q1;
    logic [N-1:0]   q2;
    logic [N-1:0]   q3;
    logic [N:0]     mid;
    logic [2*N-1:0] addend;

    vedic_mult_u #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q0));
    vedic_mult_u #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(q1));
    vedic_mult_u #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(q2));
    vedic_mult_u #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(q3));

    // Cross terms summed with one extra bit so the carry is kept
    vedic_cla #(.N(N + 1)) u_mid (
      .a  ({1'b0, q1}),
      .b  ({1'b0, q2}),
      .sum(mid)
    );

    // q0 and q3 do not overlap, so they concatenate; cross terms sit at H
    assign addend = {{(N - H - 1){1'b0}}, mid, {H{1'b0}}};

    vedic_cla #(.N(2 * N)) u_fin (
      .a  ({q3, q0}),
      .b  (addend),
      .sum(p)
    );
  end else begin : g_fallback
    // Odd widths cannot be halved; use a direct product
    assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  end

endmodule

`default_nettype wire

// File: rtl/cplx_mult_seq.sv
// ============================================================================
// Module      : cplx_mult_seq
// Description : Sequential signed complex multiplier P = A x B. A single
//               unsigned vedic WxW multiplier is time-shared over the four
//               partial products (states M0..M3); signs are applied around
//               it. Valid/ready on both sides, one transaction in flight.
// Options     : CPLX_CONJ_EN - adds conj_b input; when set the block
//               computes A x conj(B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cplx_mult_seq
  import cplx_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef CPLX_CONJ_EN
  input  logic                conj_b,
`endif
  input  logic signed [W-1:0] ar,
  input  logic signed [W-1:0] ai,
  input  logic signed [W-1:0] br,
  input  logic signed [W-1:0] bi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [2*W:0] pr,
  output logic signed [2*W:0] pi
);

  localparam int ACC_W = 2 * W + 1;

  state_t                  state_q, state_d;
  logic signed [W-1:0]     ar_q, ar_d;
  logic signed [W-1:0]     ai_q, ai_d;
  logic signed [W-1:0]     br_q, br_d;
  logic signed [W-1:0]     bi_q, bi_d;
  logic signed [ACC_W-1:0] re_q, re_d;
  logic signed [ACC_W-1:0] im_q, im_d;
  logic                    conj_sel;

  logic signed [W-1:0]     op_x;
  logic signed [W-1:0]     op_y;
  logic                    neg_op;
  logic [W-1:0]            mag_x;
  logic [W-1:0]            mag_y;
  logic [2*W-1:0]          prod;
  logic [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0] term;

`ifdef CPLX_CONJ_EN
  logic conj_q, conj_d;

  // Conjugate flag register, captured with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conj_q <= 1'b0;
    else     conj_q <= conj_d;
  end

  assign conj_sel = conj_q;
`else
  assign conj_sel = 1'b0;
`endif

  // Pick the operand pair and extra negation for the current partial product
  always_comb begin
    op_x   = ar_q;
    op_y   = br_q;
    neg_op = 1'b0;
    case (state_q)
      M1: begin
        op_x   = ai_q;
        op_y   = bi_q;
        neg_op = ~conj_sel;
      end
      M2: begin
        op_x   = ar_q;
        op_y   = bi_q;
        neg_op = conj_sel;
      end
      M3: begin
        op_x   = ai_q;
        op_y   = br_q;
        neg_op = 1'b0;
      end
      default: begin
        op_x   = ar_q;
        op_y   = br_q;
        neg_op = 1'b0;
      end
    endcase
  end

  // Magnitudes as W-bit unsigned; the most negative value maps to 2^(W-1)
  assign mag_x = op_x[W-1] ? $unsigned(-op_x) : $unsigned(op_x);
  assign mag_y = op_y[W-1] ? $unsigned(-op_y) : $unsigned(op_y);

  vedic_mult_u #(.N(W)) u_mult (
    .a(mag_x),
    .b(mag_y),
    .p(prod)
  );

  // Re-apply sign to the unsigned product after widening to the accumulator
  always_comb begin
    prod_ext = {1'b0, prod};
    if (op_x[W-1] ^ op_y[W-1] ^ neg_op) term = -$signed(prod_ext);
    else                                term = $signed(prod_ext);
  end

  // Next-state, operand capture and accumulation
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    re_d    = re_q;
    im_d    = im_q;
`ifdef CPLX_CONJ_EN
    conj_d  = conj_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ar_d    = ar;
          ai_d    = ai;
          br_d    = br;
          bi_d    = bi;
`ifdef CPLX_CONJ_EN
          conj_d  = conj_b;
`endif
          re_d    = '0;
          im_d    = '0;
          state_d = M0;
        end
      end
      M0: begin
        re_d    = re_q + term;
        state_d = M1;
      end
      M1: begin
        re_d    = re_q + term;
        state_d = M2;
      end
      M2: begin
        im_d    = im_q + term;
        state_d = M3;
      end
      M3: begin
        im_d    = im_q + term;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign pr        = re_q;
  assign pi        = im_q;

endmodule

`default_nettype wire

// File: tb/tb_cplx_mult_seq.sv
// ============================================================================
// Module      : tb_cplx_mult_seq
// Description : Self-checking bench for cplx_mult_seq (W = 8): directed
//               vector table, backpressure, mid-operation reset and a
//               back-to-back random run against an integer reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cplx_mult_seq;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] ar, ai, br, bi;
  logic              out_valid;
  logic              out_ready;
  logic signed [16:0] pr, pi;
`ifdef CPLX_CONJ_EN
  logic              conj_b;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ar; int ai; int br; int bi;
    bit conj;
    int epr; int epi;
  } vec_t;

  vec_t vecs[$];

  cplx_mult_seq #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef CPLX_CONJ_EN
    .conj_b   (conj_b),
`endif
    .ar       (ar),
    .ai       (ai),
    .br       (br),
    .bi       (bi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pr       (pr),
    .pi       (pi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a_r, input int a_i, input int b_r, input int b_i,
                              input bit cj, input int e_r, input int e_i);
    vec_t v;
    v.ar = a_r; v.ai = a_i; v.br = b_r; v.bi = b_i;
    v.conj = cj; v.epr = e_r; v.epi = e_i;
    return v;
  endfunction

  task automatic set_ops(input int a_r, input int a_i, input int b_r, input int b_i);
    ar = 8'(a_r);
    ai = 8'(a_i);
    br = 8'(b_r);
    bi = 8'(b_i);
  endtask

  // One transaction with out_ready high: latency, result and ready timing
  task automatic run_txn(input vec_t v);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("ready_wait", int'(in_ready), 1);
    set_ops(v.ar, v.ai, v.br, v.bi);
`ifdef CPLX_CONJ_EN
    conj_b = v.conj;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_ops(85, -86, 33, -44);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("latency", cnt, 5);
    chk("pr", int'(pr), v.epr);
    chk("pi", int'(pi), v.epi);
    chk("in_ready_busy", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("out_valid_drop", int'(out_valid), 0);
    chk("in_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int cnt;
    int seen;
    int cyc;
    int issued;
    int recv;
    int last_acc;
    int exp_r;
    int exp_i;
    int qpr[$];
    int qpi[$];
    int ra, ria, rb, rib;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_ops(0, 0, 0, 0);
`ifdef CPLX_CONJ_EN
    conj_b = 1'b0;
`endif

    vecs.push_back(mk(   3,    4,    1,    2, 1'b0,     -5,     10));
    vecs.push_back(mk(-128, -128, -128, -128, 1'b0,      0,  32768));
    vecs.push_back(mk( 127,  127, -128,  127, 1'b0, -32385,   -127));
    vecs.push_back(mk(  -1,    0,   -1,    0, 1'b0,      1,      0));
    vecs.push_back(mk(   0,    1,    0,    1, 1'b0,     -1,      0));
    vecs.push_back(mk(   5,   -3,   -2,    7, 1'b0,     11,     41));
    vecs.push_back(mk(-128,    0,    0, -128, 1'b0,      0,  16384));
    vecs.push_back(mk( 127,  127,  127,  127, 1'b0,      0,  32258));
    vecs.push_back(mk(-128,  127, -128, -128, 1'b0,  32640,    128));
`ifdef CPLX_CONJ_EN
    vecs.push_back(mk(   3,    4,    1,    2, 1'b1,     11,     -2));
    vecs.push_back(mk(-128, -128, -128, -128, 1'b1,  32768,      0));
    vecs.push_back(mk(   3,    4,    1,    2, 1'b0,     -5,     10));
`endif

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pr", int'(pr), 0);
    chk("rst_pi", int'(pi), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[k]) run_txn(vecs[k]);

    // Backpressure: hold result for 10 cycles while in_valid pulses
    out_ready = 1'b0;
    set_ops(3, 4, 1, 2);
`ifdef CPLX_CONJ_EN
    conj_b = 1'b0;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("bp_latency", cnt, 5);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      set_ops(int'($urandom_range(0, 255)) - 128, 9, -9, 100);
      @(posedge clk); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_pr", int'(pr), -5);
      chk("bp_pi", int'(pi), 10);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_single_transfer", seen, 0);

    // Reset pulsed during M2 discards the partial result
    set_ops(7, 7, 7, 7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_pr", int'(pr), 0);
    chk("mid_rst_pi", int'(pi), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_emit", seen, 0);
    run_txn(mk(2, 0, 0, 5, 1'b0, 0, 10));

    // Back-to-back random traffic with in_valid held high
`ifdef CPLX_CONJ_EN
    conj_b = 1'b0;
`endif
    out_ready = 1'b1;
    issued   = 0;
    recv     = 0;
    last_acc = -1;
    cyc      = 0;
    while (recv < 1000 && cyc < 7000) begin
      if (out_valid) begin
        if (qpr.size() > 0) begin
          exp_r = qpr.pop_front();
          exp_i = qpi.pop_front();
          chk("b2b_pr", int'(pr), exp_r);
          chk("b2b_pi", int'(pi), exp_i);
        end else begin
          chk("b2b_spurious", 1, 0);
        end
        recv++;
      end
      if (in_ready && issued < 1000) begin
        ra  = int'($urandom_range(0, 255)) - 128;
        ria = int'($urandom_range(0, 255)) - 128;
        rb  = int'($urandom_range(0, 255)) - 128;
        rib = int'($urandom_range(0, 255)) - 128;
        set_ops(ra, ria, rb, rib);
        in_valid = 1'b1;
        qpr.push_back(ra * rb - ria * rib);
        qpi.push_back(ra * rib + ria * rb);
        if (issued > 0) chk("b2b_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        issued++;
      end else if (issued >= 1000) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_count", recv, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
